// File: rtl/pipeline_mem_stage.sv
// rtl/pipeline_mem_stage.sv - MIPS memory stage: E/M register, byte-lane data memory, load extraction
//
// Purpose:
//   Latches the instruction leaving E, performs sw/sh/sb read-merge-write into a
//   word-organised data memory and produces the extended load result for lw/lh/lhu/lb/lbu.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   Instr_E .. PCPlus4_E E-stage values captured into the E/M register every edge
//   MUXRFWDOut           W-stage write-back value for store-data forwarding
//   ForwardRTM           1 selects MUXRFWDOut as store data, 0 the latched rt value
//   Instr_M .. PCPlus4_M latched E/M register contents
//   ReadData_M           extended load result, combinational from the addressed word
//   MemWrite_M           a store occupies M this cycle
//   MemAddr_M            byte address of the access
//   MemWData_M           merged word to be written (the current word for non-stores)

module pipeline_mem_stage #(
    parameter int DM_WORDS  = 4096,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_E,
    input  logic [31:0] ALUOutput_E,
    input  logic [31:0] WriteData_E,
    input  logic [4:0]  WriteRd_E,
    input  logic [31:0] PCPlus4_E,
    input  logic [31:0] MUXRFWDOut,
    input  logic        ForwardRTM,
    output logic [31:0] Instr_M,
    output logic [31:0] ALUOutput_M,
    output logic [4:0]  WriteRd_M,
    output logic [31:0] PCPlus4_M,
    output logic [31:0] ReadData_M,
    output logic        MemWrite_M,
    output logic [31:0] MemAddr_M,
    output logic [31:0] MemWData_M
);

    localparam int AW = $clog2(DM_WORDS);

    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;

    // E/M pipeline register
    logic [31:0] instr_d, instr_q;
    logic [31:0] alu_d, alu_q;
    logic [31:0] wdata_d, wdata_q;
    logic [4:0]  rd_d, rd_q;
    logic [31:0] pc4_d, pc4_q;

    // No stall or enable: bubbles arrive as Instr_E = 0.
    always_comb begin
        instr_d = Instr_E;
        alu_d   = ALUOutput_E;
        wdata_d = WriteData_E;
        rd_d    = WriteRd_E;
        pc4_d   = PCPlus4_E;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= 32'd0;
            alu_q   <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 5'd0;
            pc4_q   <= 32'd0;
        end else begin
            instr_q <= instr_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            pc4_q   <= pc4_d;
        end
    end

    // Decode
    logic [5:0] opcode;
    logic       is_sw, is_sh, is_sb, is_store;

    always_comb begin
        opcode   = instr_q[31:26];
        is_sw    = (opcode == OP_SW);
        is_sh    = (opcode == OP_SH);
        is_sb    = (opcode == OP_SB);
        is_store = is_sw | is_sh | is_sb;
    end

    // Data memory; upper address bits are dropped so accesses wrap.
    logic [31:0]   mem_q [DM_WORDS];
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_off;
    logic [31:0]   cur_word;
    logic [31:0]   store_data;
    logic [31:0]   merged;

    always_comb begin
        word_idx   = alu_q[AW+1:2];
        byte_off   = alu_q[1:0];
        cur_word   = mem_q[word_idx];
        store_data = ForwardRTM ? MUXRFWDOut : wdata_q;
    end

    // Read-merge: non-stores leave the current word untouched.
    always_comb begin
        merged = cur_word;
        if (is_sw) begin
            merged = store_data;
        end else if (is_sh) begin
            if (byte_off[1]) merged[31:16] = store_data[15:0];
            else             merged[15:0]  = store_data[15:0];
        end else if (is_sb) begin
            case (byte_off)
                2'd0:    merged[7:0]   = store_data[7:0];
                2'd1:    merged[15:8]  = store_data[7:0];
                2'd2:    merged[23:16] = store_data[7:0];
                default: merged[31:24] = store_data[7:0];
            endcase
        end
    end

    generate
        if (INIT_ZERO) begin : g_mem_clr
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DM_WORDS; i++) begin
                        mem_q[i] <= 32'd0;
                    end
                end else if (is_store) begin
                    mem_q[word_idx] <= merged;
                end
            end
        end else begin : g_mem_keep
            // Reset coinciding with a store must still suppress the write.
            always_ff @(posedge clk) begin
                if (is_store && !reset) begin
                    mem_q[word_idx] <= merged;
                end
            end
        end
    endgenerate

    // Load extraction
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] load_data;

    always_comb begin
        half_sel = byte_off[1] ? cur_word[31:16] : cur_word[15:0];
        case (byte_off)
            2'd0:    byte_sel = cur_word[7:0];
            2'd1:    byte_sel = cur_word[15:8];
            2'd2:    byte_sel = cur_word[23:16];
            default: byte_sel = cur_word[31:24];
        endcase
        case (opcode)
            OP_LW:   load_data = cur_word;
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'd0, half_sel};
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'd0, byte_sel};
            default: load_data = 32'd0;
        endcase
    end

    // Outputs
    always_comb begin
        Instr_M     = instr_q;
        ALUOutput_M = alu_q;
        WriteRd_M   = rd_q;
        PCPlus4_M   = pc4_q;
        ReadData_M  = load_data;
        MemWrite_M  = is_store;
        MemAddr_M   = alu_q;
        MemWData_M  = merged;
    end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// tb/tb_pipeline_mem_stage.sv - directed table-driven bench for pipeline_mem_stage

module tb_pipeline_mem_stage;

    logic        clk;
    logic        reset;
    logic [31:0] Instr_E, ALUOutput_E, WriteData_E, PCPlus4_E, MUXRFWDOut;
    logic [4:0]  WriteRd_E;
    logic        ForwardRTM;
    logic [31:0] Instr_M, ALUOutput_M, PCPlus4_M, ReadData_M, MemAddr_M, MemWData_M;
    logic [4:0]  WriteRd_M;
    logic        MemWrite_M;

    pipeline_mem_stage dut (
        .clk(clk), .reset(reset),
        .Instr_E(Instr_E), .ALUOutput_E(ALUOutput_E), .WriteData_E(WriteData_E),
        .WriteRd_E(WriteRd_E), .PCPlus4_E(PCPlus4_E),
        .MUXRFWDOut(MUXRFWDOut), .ForwardRTM(ForwardRTM),
        .Instr_M(Instr_M), .ALUOutput_M(ALUOutput_M), .WriteRd_M(WriteRd_M),
        .PCPlus4_M(PCPlus4_M), .ReadData_M(ReadData_M), .MemWrite_M(MemWrite_M),
        .MemAddr_M(MemAddr_M), .MemWData_M(MemWData_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
    localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101;
    localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100, ORI = 6'b001101;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        fwd;
        logic [31:0] mux;
        logic [31:0] exp_rd;
        logic        exp_mw;
        logic [31:0] exp_mwd;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic add(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic fwd, input logic [31:0] mux, input logic [31:0] rd,
                       input logic mw, input logic [31:0] mwd);
        vec_t v;
        v.op = op; v.addr = addr; v.wd = wd; v.fwd = fwd; v.mux = mux;
        v.exp_rd = rd; v.exp_mw = mw; v.exp_mwd = mwd;
        vecs.push_back(v);
    endtask

    task automatic drive_e(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [4:0] rd, input logic [31:0] pc4);
        Instr_E     = {op, 5'd4, 5'd8, 16'h0010};
        ALUOutput_E = addr;
        WriteData_E = wd;
        WriteRd_E   = rd;
        PCPlus4_E   = pc4;
    endtask

    initial begin
        reset = 1'b1;
        ForwardRTM = 1'b0;
        MUXRFWDOut = 32'd0;
        drive_e(6'd0, 32'd0, 32'd0, 5'd0, 32'd0);
        Instr_E = 32'd0;

        //     op   addr        wdata        fwd  mux          exp_rd       mw  exp_mwd
        add(SW,  32'h4,      32'hDEADBEEF, 0, 32'h0,        32'h0,        1, 32'hDEADBEEF);
        add(LW,  32'h4,      32'h0,        0, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF);
        add(SW,  32'h8,      32'hDEADBEEF, 0, 32'h0,        32'h0,        1, 32'hDEADBEEF);
        add(SB,  32'hA,      32'h000000AA, 0, 32'h0,        32'h0,        1, 32'hDEAABEEF);
        add(LB,  32'hA,      32'h0,        0, 32'h0,        32'hFFFFFFAA, 0, 32'hDEAABEEF);
        add(LBU, 32'hA,      32'h0,        0, 32'h0,        32'h000000AA, 0, 32'hDEAABEEF);
        add(SH,  32'hA,      32'h00008001, 0, 32'h0,        32'h0,        1, 32'h8001BEEF);
        add(LH,  32'hA,      32'h0,        0, 32'h0,        32'hFFFF8001, 0, 32'h8001BEEF);
        add(LHU, 32'hA,      32'h0,        0, 32'h0,        32'h00008001, 0, 32'h8001BEEF);
        add(LH,  32'h8,      32'h0,        0, 32'h0,        32'hFFFFBEEF, 0, 32'h8001BEEF);
        add(SW,  32'h20,     32'h11111111, 1, 32'h22222222, 32'h0,        1, 32'h22222222);
        add(LW,  32'h20,     32'h0,        0, 32'h0,        32'h22222222, 0, 32'h22222222);
        add(SW,  32'h4000,   32'h5A5A5A5A, 0, 32'h0,        32'h0,        1, 32'h5A5A5A5A);
        add(LW,  32'h0,      32'h0,        0, 32'h0,        32'h5A5A5A5A, 0, 32'h5A5A5A5A);
        add(ORI, 32'h0,      32'hFFFFFFFF, 1, 32'h33333333, 32'h0,        0, 32'h5A5A5A5A);
        add(LW,  32'h4000,   32'h0,        0, 32'h0,        32'h5A5A5A5A, 0, 32'h5A5A5A5A);
        add(SB,  32'h3,      32'h12345677, 0, 32'h0,        32'h0,        1, 32'h775A5A5A);
        add(LB,  32'h3,      32'h0,        0, 32'h0,        32'h00000077, 0, 32'h775A5A5A);
        add(LBU, 32'h1,      32'h0,        0, 32'h0,        32'h0000005A, 0, 32'h775A5A5A);
        add(SH,  32'h4,      32'hABCD1234, 0, 32'h0,        32'h0,        1, 32'hDEAD1234);
        add(LH,  32'h5,      32'h0,        0, 32'h0,        32'h00001234, 0, 32'hDEAD1234);
        add(LW,  32'h7,      32'h0,        0, 32'h0,        32'hDEAD1234, 0, 32'hDEAD1234);

        // Reset state
        #3;
        chk("reset_instr", Instr_M, 32'd0);
        chk("reset_alu", ALUOutput_M, 32'd0);
        chk("reset_rd", {27'd0, WriteRd_M}, 32'd0);
        chk("reset_pc4", PCPlus4_M, 32'd0);
        chk("reset_memwrite", {31'd0, MemWrite_M}, 32'd0);
        chk("reset_mwdata", MemWData_M, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive_e(vecs[i].op, vecs[i].addr, vecs[i].wd, 5'(i + 1), 32'h1000 + 32'(i * 4));
            @(posedge clk);
            #1;
            ForwardRTM = vecs[i].fwd;
            MUXRFWDOut = vecs[i].mux;
            @(negedge clk);
            chk($sformatf("v%0d_instr", i), Instr_M, {vecs[i].op, 5'd4, 5'd8, 16'h0010});
            chk($sformatf("v%0d_alu", i), ALUOutput_M, vecs[i].addr);
            chk($sformatf("v%0d_memaddr", i), MemAddr_M, vecs[i].addr);
            chk($sformatf("v%0d_wrd", i), {27'd0, WriteRd_M}, {27'd0, 5'(i + 1)});
            chk($sformatf("v%0d_pc4", i), PCPlus4_M, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d_readdata", i), ReadData_M, vecs[i].exp_rd);
            chk($sformatf("v%0d_memwrite", i), {31'd0, MemWrite_M}, {31'd0, vecs[i].exp_mw});
            chk($sformatf("v%0d_mwdata", i), MemWData_M, vecs[i].exp_mwd);
        end

        // Reset mid-run clears the pipeline register at once and, with INIT_ZERO, the memory
        ForwardRTM = 1'b0;
        drive_e(SW, 32'h10, 32'h12345678, 5'd9, 32'h2000);
        @(posedge clk);
        @(negedge clk);
        drive_e(LW, 32'h10, 32'h0, 5'd10, 32'h2004);
        @(posedge clk);
        #1;
        chk("pre_reset_lw", ReadData_M, 32'h12345678);
        #2;
        reset = 1'b1;
        #1;
        chk("async_instr", Instr_M, 32'd0);
        chk("async_alu", ALUOutput_M, 32'd0);
        chk("async_readdata", ReadData_M, 32'd0);
        chk("async_memwrite", {31'd0, MemWrite_M}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_e(LW, 32'h10, 32'h0, 5'd11, 32'h2008);
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_instr", Instr_M, {LW, 5'd4, 5'd8, 16'h0010});
        chk("post_reset_lw", ReadData_M, 32'd0);
        drive_e(LW, 32'h4, 32'h0, 5'd12, 32'h200C);
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_lw4", ReadData_M, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
